// File: rtl/last_beat_tagger_pkg.sv
// Shared types for the last-beat tagger: decision codes and the record layout.
// No logic lives here; latency and backpressure are properties of the users.
// The record width helper keeps the FIFO width in step with the beat counter.
package last_beat_pkg;

    // Per-cycle outcome of the beat/completion arbitration, highest priority first
    typedef enum logic [2:0] {
        NONE,
        TIEOFF,
        WRAP_TIE,
        ORPHAN_TIE,
        START,
        INTERIOR,
        LATE
    } dec_e;

    localparam int unsigned BEAT_CNT_WIDTH_DEF = 10;

    // One record per previous beat: was it the last beat, and how long was the packet
    typedef struct packed {
        logic                          last;
        logic [BEAT_CNT_WIDTH_DEF-1:0] cnt;
    } beat_rec_t;

    // Record is the last flag on top of the beat count
    function automatic int unsigned rec_width(input int unsigned cnt_width);
        return cnt_width + 1;
    endfunction

endpackage

// File: rtl/last_beat_tagger_if.sv
// Beat-address channel in, tagged-record channel out, bundled for the tagger.
// Pure wiring, no latency.
// Both channels are valid/ready; slave is the tagger's view, master the feeder's.
interface last_beat_tagger_if #(
    parameter int ADDR_WIDTH     = 12,
    parameter int BEAT_CNT_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0]     i_addr_data;
    logic                      i_addr_valid;
    logic                      i_addr_ready;
    logic                      o_prev_beat_last;
    logic [BEAT_CNT_WIDTH-1:0] o_prev_beat_cnt;
    logic                      o_prev_beat_valid;
    logic                      o_prev_beat_ready;

    modport master (
        output i_addr_data,
        output i_addr_valid,
        input  i_addr_ready,
        input  o_prev_beat_last,
        input  o_prev_beat_cnt,
        input  o_prev_beat_valid,
        output o_prev_beat_ready
    );

    modport slave (
        input  i_addr_data,
        input  i_addr_valid,
        output i_addr_ready,
        output o_prev_beat_last,
        output o_prev_beat_cnt,
        output o_prev_beat_valid,
        input  o_prev_beat_ready
    );
endinterface

// File: rtl/last_beat_tagger_beat_rec_fifo.sv
// Synchronous first-word-fall-through FIFO for tagger records, with free count.
// Latency: a written word is visible on rd_vld_o the following cycle.
// Writes when full are dropped unless a read happens in the same cycle.
module beat_rec_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_vld_i,
    input  logic [WIDTH-1:0]         wr_dat_i,
    input  logic                     rd_rdy_i,
    output logic                     rd_vld_o,
    output logic [WIDTH-1:0]         rd_dat_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   free_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             rd_fire;
    logic             wr_fire;

    assign rd_vld_o = (cnt_q != '0);
    assign full_o   = (cnt_q == (AW+1)'(DEPTH));
    assign free_o   = (AW+1)'(DEPTH) - cnt_q;
    assign rd_fire  = rd_rdy_i & rd_vld_o;
    // A full FIFO can still take a word when the head leaves in the same cycle
    assign wr_fire  = wr_vld_i & (~full_o | rd_fire);
    // Empty FIFO presents zeros so nothing stale leaks out, including in reset
    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;

    // Storage array; contents are meaningless until counted in
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/last_beat_tagger.sv
// Tags each DMA AW beat with whether the previous beat closed a packet.
// Latency: the record for a beat or completion appears the following cycle.
// Beat ready drops at max outstanding or with <2 free record slots; completions never stall.
module last_beat_tagger
    import last_beat_pkg::*;
#(
    parameter int ADDR_WIDTH        = 12,
    parameter int BUS_WIDTH         = 32,
    parameter int OUTSTANDING_WIDTH = 2,
    parameter int BEAT_CNT_WIDTH    = 10,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_WIDTH-1:0]        i_base_addr,
    input  logic                         i_dma_complete,
    last_beat_tagger_if.slave            bus,
    output logic [OUTSTANDING_WIDTH:0]   o_outstanding,
    output logic                         o_err_spurious,
    output logic                         o_err_orphan,
    output logic                         o_err_overflow
);
    localparam int          OW         = OUTSTANDING_WIDTH + 1;
    localparam int          FAW        = $clog2(FIFO_DEPTH);
    localparam int unsigned REC_W      = rec_width(BEAT_CNT_WIDTH);
    localparam int          BEAT_BYTES = BUS_WIDTH / 8;
    localparam logic [OW-1:0] MAX_OUT  = OW'(1) << OUTSTANDING_WIDTH;

    // Beat addresses step by BEAT_BYTES; the tagger only compares against base,
    // so a sub-byte bus is the one configuration with no meaning here.
    if (BEAT_BYTES == 0) begin : g_sub_byte_bus
    end

    logic                      run_q;
    logic [ADDR_WIDTH-1:0]     base_q;
    logic [OW-1:0]             start_q;
    logic [OW-1:0]             done_q;
    logic [BEAT_CNT_WIDTH-1:0] bcnt_q;
    logic [BEAT_CNT_WIDTH-1:0] bcnt_d;
    logic                      err_spurious_q;
    logic                      err_orphan_q;
    logic                      err_overflow_q;

    logic [OW-1:0]             out_cnt;
    logic                      idle;
    logic                      out_one;
    logic                      ready;
    logic                      beat;
    logic                      wrap;
    dec_e                      dec;
    logic                      start_inc;
    logic                      done_inc;
    logic                      spurious_set;
    logic                      orphan_set;
    logic                      overflow_set;
    logic                      rec_wr;
    logic [REC_W-1:0]          rec_dat;
    logic                      fifo_full;
    logic                      fifo_vld;
    logic                      fifo_rd;
    logic [REC_W-1:0]          fifo_dat;
    logic [FAW:0]              fifo_free;

    assign out_cnt = start_q - done_q;
    assign idle    = (out_cnt == '0);
    assign out_one = (out_cnt == OW'(1));
    // run_q keeps ready low through reset and the first cycle after release
    assign ready   = run_q & (out_cnt != MAX_OUT) & (fifo_free >= (FAW+1)'(2));
    assign beat    = bus.i_addr_valid & ready;
    assign wrap    = beat & (bus.i_addr_data == base_q);

    // Arbitrate beat vs completion and derive counter/record/flag actions
    always_comb begin
        dec          = NONE;
        start_inc    = 1'b0;
        done_inc     = 1'b0;
        spurious_set = 1'b0;
        orphan_set   = 1'b0;
        rec_wr       = 1'b0;
        rec_dat      = '0;
        bcnt_d       = bcnt_q;

        if (i_dma_complete && idle) begin
            // Nothing outstanding to complete; a concurrent beat is treated as at idle
            spurious_set = 1'b1;
            if (beat) begin
                dec = START;
            end
        end else if (i_dma_complete && out_one && !beat) begin
            dec = TIEOFF;
        end else if (i_dma_complete && out_one && wrap) begin
            dec = WRAP_TIE;
        end else if (i_dma_complete && out_one) begin
            dec = ORPHAN_TIE;
        end else if (beat && idle) begin
            dec = START;
        end else if (beat) begin
            dec = INTERIOR;
        end else if (i_dma_complete) begin
            dec = LATE;
        end

        case (dec)
            TIEOFF: begin
                rec_wr   = 1'b1;
                rec_dat  = {1'b1, bcnt_q};
                done_inc = 1'b1;
            end
            WRAP_TIE: begin
                // Closing and reopening in one cycle: a single record, out unchanged
                rec_wr    = 1'b1;
                rec_dat   = {1'b1, bcnt_q};
                done_inc  = 1'b1;
                start_inc = 1'b1;
                bcnt_d    = BEAT_CNT_WIDTH'(1);
            end
            ORPHAN_TIE: begin
                // Packet closes; the non-wrap beat belongs to nothing and is dropped
                rec_wr     = 1'b1;
                rec_dat    = {1'b1, bcnt_q};
                done_inc   = 1'b1;
                orphan_set = 1'b1;
            end
            START: begin
                if (wrap) begin
                    start_inc = 1'b1;
                    bcnt_d    = BEAT_CNT_WIDTH'(1);
                end else begin
                    orphan_set = 1'b1;
                end
            end
            INTERIOR: begin
                rec_wr   = 1'b1;
                done_inc = i_dma_complete;
                if (wrap) begin
                    rec_dat   = {1'b1, bcnt_q};
                    start_inc = 1'b1;
                    bcnt_d    = BEAT_CNT_WIDTH'(1);
                end else begin
                    rec_dat = '0;
                    bcnt_d  = (&bcnt_q) ? bcnt_q : bcnt_q + BEAT_CNT_WIDTH'(1);
                end
            end
            LATE: begin
                done_inc = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign fifo_rd      = fifo_vld & bus.o_prev_beat_ready;
    assign overflow_set = rec_wr & fifo_full & ~fifo_rd;

    // Counters, base sampling, beat count and sticky error flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q          <= 1'b0;
            base_q         <= '0;
            start_q        <= '0;
            done_q         <= '0;
            bcnt_q         <= '0;
            err_spurious_q <= 1'b0;
            err_orphan_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (idle) begin
                base_q <= i_base_addr;
            end
            if (start_inc) begin
                start_q <= start_q + OW'(1);
            end
            if (done_inc) begin
                done_q <= done_q + OW'(1);
            end
            bcnt_q         <= bcnt_d;
            err_spurious_q <= err_spurious_q | spurious_set;
            err_orphan_q   <= err_orphan_q | orphan_set;
            err_overflow_q <= err_overflow_q | overflow_set;
        end
    end

    beat_rec_fifo #(
        .WIDTH (int'(REC_W)),
        .DEPTH (FIFO_DEPTH)
    ) u_rec_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_vld_i (rec_wr),
        .wr_dat_i (rec_dat),
        .rd_rdy_i (bus.o_prev_beat_ready),
        .rd_vld_o (fifo_vld),
        .rd_dat_o (fifo_dat),
        .full_o   (fifo_full),
        .free_o   (fifo_free)
    );

    assign bus.i_addr_ready      = ready;
    assign bus.o_prev_beat_valid = fifo_vld;
    assign bus.o_prev_beat_last  = fifo_dat[REC_W-1];
    assign bus.o_prev_beat_cnt   = fifo_dat[BEAT_CNT_WIDTH-1:0];
    assign o_outstanding         = out_cnt;
    assign o_err_spurious        = err_spurious_q;
    assign o_err_orphan          = err_orphan_q;
    assign o_err_overflow        = err_overflow_q;

endmodule

// File: doc/last_beat_tagger.md
Name: last_beat_tagger

Overview:
Successor to the single-channel TLAST calculator. It watches GEM DMA AW-channel beat addresses and the PS "DMA complete" strobe, and decides for each accepted beat whether the previous beat closed a packet. It emits one record per previous beat, carrying last and the packet beat count, into an internal record FIFO with downstream backpressure. Relative to the previous generation it adds the following:
- legal simultaneous beat and completion
- runtime base address
- parametrised outstanding depth
- spurious and orphan detection
- sticky error flags

Parameters:
ADDR_WIDTH, 12, width of beat address
BUS_WIDTH, 32, data bus width in bits; BEAT_BYTES = BUS_WIDTH/8 (informational)
OUTSTANDING_WIDTH, 2, MAX_OUTSTANDING = 2**OUTSTANDING_WIDTH packets
BEAT_CNT_WIDTH, 10, width of per-packet beat count (saturating)
FIFO_DEPTH, 8, record FIFO depth, power of two, >= 4

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_base_addr  in  ADDR_WIDTH  wrap address; sampled into a register on every cycle in which the tracker is idle
i_addr_data  in  ADDR_WIDTH  beat address
i_addr_valid  in  1  beat valid
i_addr_ready  out  1  beat ready
i_dma_complete  in  1  single-cycle completion strobe; not backpressurable
o_prev_beat_last  out  1  record: previous beat was last
o_prev_beat_cnt  out  BEAT_CNT_WIDTH  beats in the closed packet; valid when last=1, otherwise 0
o_prev_beat_valid  out  1  record valid
o_prev_beat_ready  in  1  record ready
o_outstanding  out  OUTSTANDING_WIDTH+1  current start minus done
o_err_spurious  out  1  sticky: completion arrived with outstanding==0
o_err_orphan  out  1  sticky: non-wrap beat accepted with outstanding==0
o_err_overflow  out  1  sticky: record dropped because the FIFO was full

Behaviour:
Reset:
- Asynchronous, active-low. Clears all counters, the FIFO and the sticky flags.
- The base register loads i_base_addr on reset release.
- All outputs are 0 during reset.

Definitions:
- out = start_cnt - done_cnt, modulo 2**(OUTSTANDING_WIDTH+1).
- Idle means out==0.
- beat = i_addr_valid & i_addr_ready.
- wrap = beat & (i_addr_data == base_reg).
- i_addr_ready = (out != MAX_OUTSTANDING) & (fifo_free >= 2), computed combinationally from registered state only.

Per-cycle decision (evaluated in this priority order; at most one record written per cycle):
1. i_dma_complete & out==0:
   - Spurious. done_cnt unchanged; set o_err_spurious.
   - The beat, if present, is then handled by rules 5/6.
2. i_dma_complete & out==1 & !beat: tie-off. Write {last=1, cnt=beat_cnt}; done++.
3. i_dma_complete & out==1 & wrap:
   - Write a single {last=1, cnt=beat_cnt}.
   - start++, done++ (out stays 1); beat_cnt <= 1.
4. i_dma_complete & out==1 & beat & !wrap:
   - Write {last=1, cnt=beat_cnt}; done++; set o_err_orphan.
   - The beat is discarded (not counted).
5. beat & out==0 (or spurious completion with a beat):
   - wrap: start++, beat_cnt <= 1, no record.
   - !wrap: set o_err_orphan, no record.
6. beat & out>=1, no qualifying completion:
   - Write {last=wrap, cnt = wrap ? beat_cnt : 0}.
   - If wrap: start++, beat_cnt <= 1. Otherwise beat_cnt <= beat_cnt+1, saturating at all-ones.
7. i_dma_complete & out>=2: too-late completion. done++, no record of its own; rule 6 still applies to a concurrent beat.

Record FIFO:
- Latency: a record is visible on o_prev_beat_valid the cycle after the triggering event (registered FIFO, first-word fall-through).
- A write when the FIFO is full is dropped and sets o_err_overflow; the read side is unaffected.
- Simultaneous read and write is legal when full.

Stalls and reset:
- i_addr_data is held stable while valid & !ready; the block does not check this.
- o_prev_beat_* is held stable while valid & !ready.
- Reset mid-packet discards all in-flight records; the next accepted beat must be a wrap to start a packet.

Decomposition:
Package last_beat_pkg holds:
- record struct typedef {last, cnt} and the width function for BEAT_CNT_WIDTH
- decision enum: NONE, TIEOFF, WRAP_TIE, ORPHAN_TIE, START, INTERIOR, LATE

One sub-module: beat_rec_fifo, a synchronous FWFT FIFO with free-count output, parametrised by width and depth, using the same asynchronous active-low reset.

Test Plan:
- Single packet: base=0, beats at 0, 4, 8, 12, then completion 3 cycles later.
  Expect records L0, L0, L0, then {1, 4}; out ends at 0; no error flags.
- Back-to-back: packet A at 0..12, packet B starting at 0 with no gap, then two completions.
  Expect {1, 4} at B's first beat; the first completion writes no record; the second writes {1, B_len}.
- Simultaneous: completion on the same cycle as B's wrap beat with out==1.
  Expect exactly one {1, 4} record; out stays 1; B beat_cnt=1.
- Saturation: OUTSTANDING_WIDTH=2, 4 single-beat packets with no completions.
  Expect ready falls once out==4; ready rises the cycle after one completion.
- Backpressure: hold o_prev_beat_ready=0 for 20 cycles during a 10-beat packet.
  Expect ready drops at fifo_free<2; no o_err_overflow; record order preserved after release.
- Errors and reset:
  - Completion with out==0 sets o_err_spurious.
  - A non-base beat at idle sets o_err_orphan.
  - Asserting reset_n=0 mid-packet clears all flags, records and counts within the same cycle.
